// File: rtl/osiris_i_pkg.sv
// Shared definitions for the Osiris I pipeline: datapath width, bubble
// instruction and the fetch-stage state encoding.
package osiris_i_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pipe_reg_if_id.sv
// Generic pipeline register: flush beats stall beats load; with no load and
// no stall it fills with a bubble while keeping the last PC pair.
module pipe_reg_if_id
    import osiris_i_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = osiris_i_pkg::NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            instr_d = instr_q;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, skid
// register for responses that land during a stall, and the IF/ID register.
module stage_fetch
    import osiris_i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = osiris_i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            i_rst_IF,
    input  logic            i_stall_IF,
    input  logic            i_flush_ID,
    input  logic            i_pc_src_EX,
    input  logic [XLEN-1:0] i_pc_target_EX,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr_ID,
    output logic [XLEN-1:0] o_pc_ID,
    output logic [XLEN-1:0] o_pc_plus4_ID,
    output logic            o_valid_ID
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            kill_q, kill_d;

    logic            req_raw;
    logic            accept;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] load_pc;

    // Back-to-back issue in S_WAIT only when the live response is consumed now.
    always_comb begin
        req_raw = 1'b0;
        unique case (state_q)
            S_FETCH: req_raw = 1'b1;
            S_WAIT:  req_raw = i_imem_rvalid && !kill_q && !i_stall_IF;
            default: req_raw = 1'b0;
        endcase
    end

    assign o_imem_req  = req_raw && i_rst_IF && !i_pc_src_EX;
    assign accept      = o_imem_req && i_imem_ready;
    assign o_imem_addr = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        load         = 1'b0;
        load_instr   = i_imem_rdata;
        load_pc      = req_pc_q;

        unique case (state_q)
            S_FETCH: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (kill_q || i_pc_src_EX) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (i_stall_IF) begin
                        skid_instr_d = i_imem_rdata;
                        skid_pc_d    = req_pc_q;
                        state_d      = S_HOLD;
                    end else begin
                        load    = 1'b1;
                        state_d = accept ? S_WAIT : S_FETCH;
                    end
                end else if (i_pc_src_EX) begin
                    // The response still owed to us belongs to the old path.
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_pc_src_EX) begin
                    state_d = S_FETCH;
                end else if (!i_stall_IF) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc    = skid_pc_q;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
        if (i_pc_src_EX) begin
            pc_d = i_pc_target_EX;
        end
    end

    always_ff @(posedge clk or negedge i_rst_IF) begin
        if (!i_rst_IF) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    pipe_reg_if_id #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i      (clk),
        .rst_ni     (i_rst_IF),
        .flush_i    (i_flush_ID),
        .stall_i    (i_stall_IF),
        .load_i     (load),
        .instr_i    (load_instr),
        .pc_i       (load_pc),
        .pc_plus4_i (load_pc + 32'd4),
        .instr_o    (o_instr_ID),
        .pc_o       (o_pc_ID),
        .pc_plus4_o (o_pc_plus4_ID),
        .valid_o    (o_valid_ID)
    );

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed vector table, async reset mid-request, then
// randomized traffic against a queue-based fetch model.
module tb_stage_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        i_rst_IF;
    logic        i_stall_IF;
    logic        i_flush_ID;
    logic        i_pc_src_EX;
    logic [31:0] i_pc_target_EX;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr_ID;
    logic [31:0] o_pc_ID;
    logic [31:0] o_pc_plus4_ID;
    logic        o_valid_ID;

    int n_checks;
    int n_fail;

    stage_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .i_rst_IF       (i_rst_IF),
        .i_stall_IF     (i_stall_IF),
        .i_flush_ID     (i_flush_ID),
        .i_pc_src_EX    (i_pc_src_EX),
        .i_pc_target_EX (i_pc_target_EX),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ready   (i_imem_ready),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_instr_ID     (o_instr_ID),
        .o_pc_ID        (o_pc_ID),
        .o_pc_plus4_ID  (o_pc_plus4_ID),
        .o_valid_ID     (o_valid_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] target;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        killed;
    } out_t;

    vec_t vecs[20];

    // Memory model: one pending request, response after lat cycles.
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;

    // Fetch model state.
    out_t        out_q[$];
    logic [31:0] skid_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcid;
    logic [31:0] m_pc4;
    logic        m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0100;
    endfunction

    function automatic vec_t mk(input logic s, input logic f, input logic p,
                                input logic [31:0] t, input int lat, input logic rq,
                                input logic [31:0] a, input logic [31:0] ins,
                                input logic v, input logic [31:0] pc, input logic [31:0] pc4);
        vec_t x;
        x.stall = s;  x.flush = f;  x.pcsrc = p;  x.target = t;  x.lat = lat;
        x.req = rq;   x.addr = a;   x.instr = ins; x.valid = v; x.pc = pc; x.pc4 = pc4;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rq, input logic [31:0] a,
                            input logic [31:0] ins, input logic v,
                            input logic [31:0] pc, input logic [31:0] pc4);
        chk_bit({tag, ".req"}, o_imem_req, rq);
        chk({tag, ".addr"}, o_imem_addr, a);
        chk({tag, ".instr"}, o_instr_ID, ins);
        chk_bit({tag, ".valid"}, o_valid_ID, v);
        chk({tag, ".pc"}, o_pc_ID, pc);
        chk({tag, ".pc4"}, o_pc_plus4_ID, pc4);
    endtask

    task automatic drive(input logic s, input logic f, input logic p,
                         input logic [31:0] t, input logic r);
        i_stall_IF     = s;
        i_flush_ID     = f;
        i_pc_src_EX    = p;
        i_pc_target_EX = t;
        i_imem_ready   = r;
    endtask

    task automatic mem_clear();
        mem_busy      = 1'b0;
        mem_addr      = '0;
        mem_cnt       = 0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
    endtask

    // Capture the handshake just before the edge, then update the memory.
    task automatic advance(input int lat);
        logic        acc;
        logic [31:0] a;
        acc = o_imem_req && i_imem_ready;
        a   = o_imem_addr;
        @(posedge clk);
        #1;
        if (i_imem_rvalid) mem_busy = 1'b0;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = a;
            mem_cnt  = lat - 1;
        end
        if (mem_busy && mem_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mem_addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
            if (mem_busy) mem_cnt--;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst_IF = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        mem_clear();

        //              stall flush pcsrc target        lat req  addr          instr         v     pc            pc4
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h000, NOP,     1'b0, 32'h000, 32'h000);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h004, NOP,     1'b0, 32'h000, 32'h000);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h008, 32'h100, 1'b1, 32'h000, 32'h004);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h00C, 32'h104, 1'b1, 32'h004, 32'h008);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h00C, 32'h104, 1'b1, 32'h004, 32'h008);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h00C, 32'h104, 1'b1, 32'h004, 32'h008);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h00C, 32'h104, 1'b1, 32'h004, 32'h008);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h00C, 32'h108, 1'b1, 32'h008, 32'h00C);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h010, NOP,     1'b0, 32'h008, 32'h00C);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h200, 2, 1'b0, 32'h014, 32'h10C, 1'b1, 32'h00C, 32'h010);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b0, 32'h200, NOP,     1'b0, 32'h00C, 32'h010);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h200, NOP,     1'b0, 32'h00C, 32'h010);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h204, NOP,     1'b0, 32'h00C, 32'h010);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   2, 1'b0, 32'h208, 32'h300, 1'b1, 32'h200, 32'h204);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h208, NOP,     1'b0, 32'h200, 32'h204);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,   2, 1'b0, 32'h20C, 32'h304, 1'b1, 32'h204, 32'h208);
        vecs[16] = mk(1'b1, 1'b1, 1'b1, 32'h400, 1, 1'b0, 32'h20C, NOP,     1'b0, 32'h204, 32'h208);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h400, NOP,     1'b0, 32'h204, 32'h208);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h404, NOP,     1'b0, 32'h204, 32'h208);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h408, 32'h500, 1'b1, 32'h400, 32'h404);

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        i_rst_IF = 1'b1;

        for (int k = 0; k < 20; k++) begin
            drive(vecs[k].stall, vecs[k].flush, vecs[k].pcsrc, vecs[k].target, 1'b1);
            #3;
            chk_outs($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].instr,
                     vecs[k].valid, vecs[k].pc, vecs[k].pc4);
            advance(vecs[k].lat);
        end

        // A request to 0x408 is outstanding here; reset must act at once.
        #1;
        i_rst_IF = 1'b0;
        mem_clear();
        #1;
        chk_outs("async_rst", 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        i_rst_IF = 1'b1;

        out_q.delete();
        skid_q.delete();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_pcid  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic        s, f, p, r, ereq, acc, deliver;
            logic [31:0] t, d_pc;
            int          lat;
            out_t        o;
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 9) == 0);
            p   = (i > 0) && ($urandom_range(0, 11) == 0);
            t   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
            r   = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 3);
            drive(s, f, p, t, r);
            #3;

            // Idle (nothing pending, nothing parked) always asks; otherwise only
            // when the pending response is consumed straight into IF/ID.
            ereq = !p && ((out_q.size() == 0 && skid_q.size() == 0) ||
                          (out_q.size() != 0 && i_imem_rvalid && !out_q[0].killed && !s));
            chk_outs(i == 0 ? "post_rst" : "rand", ereq, m_pc, m_instr, m_valid, m_pcid, m_pc4);

            deliver = 1'b0;
            d_pc    = '0;
            if (i_imem_rvalid && out_q.size() != 0) begin
                o = out_q.pop_front();
                if (!o.killed && !p) begin
                    if (s) skid_q.push_back(o.pc);
                    else begin
                        deliver = 1'b1;
                        d_pc    = o.pc;
                    end
                end
            end else if (skid_q.size() != 0) begin
                if (p) skid_q.delete();
                else if (!s) begin
                    deliver = 1'b1;
                    d_pc    = skid_q.pop_front();
                end
            end
            if (p && out_q.size() != 0) begin
                o        = out_q[0];
                o.killed = 1'b1;
                out_q[0] = o;
            end

            acc = ereq && r;
            if (acc) begin
                o.pc     = m_pc;
                o.killed = 1'b0;
                out_q.push_back(o);
                m_pc = m_pc + 32'd4;
            end
            if (p) m_pc = t;

            if (f) begin
                m_instr = NOP;
                m_valid = 1'b0;
            end else if (!s) begin
                if (deliver) begin
                    m_instr = mem_word(d_pc);
                    m_valid = 1'b1;
                    m_pcid  = d_pc;
                    m_pc4   = d_pc + 32'd4;
                end else begin
                    m_instr = NOP;
                    m_valid = 1'b0;
                end
            end

            advance(lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction fetch stage of the Osiris I pipeline, directly upstream of `stage_decode`. It holds the PC and issues word fetches over a req/ready, rvalid instruction-memory handshake with at most one request outstanding. It owns the IF/ID pipeline register whose `o_instr_ID` drives the decode stage's `i_instr_ID`. It also honours the hazard unit's stall and flush and the EX-stage branch/jump redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_IF`  in  1  reset, asynchronous, active-low.
- `i_stall_IF`  in  1  hold the PC and IF/ID register.
- `i_flush_ID`  in  1  squash the IF/ID contents to a bubble.
- `i_pc_src_EX`  in  1  redirect the PC to `i_pc_target_EX`.
- `i_pc_target_EX`  in  32  branch/jump target.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  32  fetch address; equals the PC.
- `i_imem_ready`  in  1  memory accepts the request this cycle.
- `i_imem_rvalid`  in  1  response valid.
- `i_imem_rdata`  in  32  fetched instruction.
- `o_instr_ID`  out  32  IF/ID instruction.
- `o_pc_ID`  out  32  PC of `o_instr_ID`.
- `o_pc_plus4_ID`  out  32  `o_pc_ID + 4`.
- `o_valid_ID`  out  1  IF/ID holds a real instruction.

## Operation
- State machine with three states:
  - S_FETCH: a request may be issued.
  - S_WAIT: one request is outstanding.
  - S_HOLD: a response is parked in the skid register.
- Internal registers:
  - `pc`
  - `req_pc`: PC of the outstanding request.
  - `kill`: discard the outstanding response.
  - `skid_instr` and `skid_pc`.
- Accept = `o_imem_req && i_imem_ready`. On accept: `req_pc <= pc`, `pc <= pc + 4` (mod 2^32, wraps silently). Accept in S_FETCH moves to S_WAIT.
- `o_imem_req` is high in either case below. It is forced low while `i_rst_IF` is low or `i_pc_src_EX` is high.
  - In S_FETCH.
  - In S_WAIT on the cycle a response arrives with `i_imem_rvalid=1`, `kill=0` and `i_stall_IF=0`. This is a back-to-back issue; the state stays S_WAIT.
- Response with `kill=0`:
  - If not stalled, load IF/ID: `{rdata, req_pc, req_pc+4, valid=1}`.
  - If stalled, write the skid register and move to S_HOLD.
- Response with `kill=1`: discard it, clear `kill`, go to S_FETCH.
- In S_HOLD with no stall: load IF/ID from the skid register, go to S_FETCH. No request is issued in S_HOLD.
- No stall and no new instruction this cycle: IF/ID loads `NOP_INSTR`, `valid=0`; `o_pc_ID` and `o_pc_plus4_ID` are held.
- IF/ID update priority: `i_flush_ID` (NOP, valid 0) > `i_stall_IF` (hold) > load.
- Redirect (`i_pc_src_EX=1`) takes priority over stall for the PC: `pc <= i_pc_target_EX`.
  - S_WAIT with no response this cycle: set `kill`.
  - S_WAIT with a response this cycle: discard it, go to S_FETCH.
  - S_HOLD: drop the skid contents, go to S_FETCH.
  - Redirect does not by itself flush IF/ID; the hazard unit asserts `i_flush_ID` alongside it.
- Flush without redirect leaves the skid register and the outstanding request intact.
- Reset (asynchronous, any time): state S_FETCH, `pc=RESET_PC`, `kill=0`, skid empty, `o_instr_ID=NOP_INSTR`, `o_pc_ID=0`, `o_pc_plus4_ID=0`, `o_valid_ID=0`, `o_imem_req=0`. Instruction memory shares this reset, so no response crosses a reset.

## Timing
- `i_imem_rvalid` arrives one or more cycles after accept; exactly one response per accept.
- A response sampled at edge N appears on `o_instr_ID` after edge N, unless stalled or killed.
- Zero-wait memory (rvalid the cycle after accept) with no stalls sustains one instruction per cycle.
- Redirect at edge N: the first request to the target is issued in the cycle after N if no request is outstanding. Otherwise it waits for the killed response.
- `o_imem_req` depends combinationally on `i_imem_rvalid`, `i_stall_IF` and `i_pc_src_EX`. `o_imem_addr` is registered.

## Structure
- Shared package `osiris_i_pkg`: `NOP_INSTR` constant, fetch state encoding, `XLEN=32`.
- One sub-module, `pipe_reg_if_id`: IF/ID register with flush/stall priority and NOP reset value. It is reusable for the other pipeline registers.

## Test plan
- Reset release, `RESET_PC=0`, zero-wait memory returning `addr|0x100` -> addresses 0,4,8 on consecutive cycles; `o_instr_ID` = 0x100,0x104,0x108 with `o_valid_ID=1` each cycle.
- Memory with 2-cycle rvalid latency -> `o_valid_ID` alternates with bubbles (`NOP_INSTR`, valid 0); PC sequence 0,4,8 unchanged.
- `i_stall_IF` high 3 cycles while a response arrives -> IF/ID held, skid captures it, no request; after release the skid instruction appears in the next cycle, then fetch resumes at the next PC.
- Redirect to 0x200 while a request to 0x8 is outstanding -> the 0x8 response is discarded and never reaches `o_instr_ID`; next request address is 0x200.
- Redirect together with `i_flush_ID`, also under `i_stall_IF` -> `o_instr_ID=0x00000013`, `o_valid_ID=0`, next fetch at the target.
- Reset asserted mid-S_WAIT -> all outputs immediately at reset values; after release the first address is `RESET_PC`.
